// File: rtl/neo_prot_bank_if.sv
// 68K PORT bus, P2 ROM address and cart-loader configuration bundle for neo_prot_bank.
// Latency: none, wires only.
// Backpressure: none; strobes and CFG_WR are one-way pulses with no ready path.
interface neo_prot_bank_if #(
    parameter int ADDR_W = 19,
    parameter int P2_W   = 24
);
    logic [ADDR_W-1:0] M68K_ADDR;
    logic [15:0]       M68K_DIN;
    logic [15:0]       M68K_DOUT;
    logic [1:0]        M68K_DOE;
    logic              nPORTOEL;
    logic              nPORTOEU;
    logic              nPORTWEL;
    logic              nPORTWEU;
    logic [15:0]       PROM_DATA;
    logic              CFG_WR;
    logic [7:0]        CFG_ADDR;
    logic [31:0]       CFG_DATA;
    logic [P2_W-1:0]   P2_ADDR;
    logic              ACTIVE;

    // 68K / cart-loader / ROM side: drives the bus and config, consumes read data and P2 address.
    modport master (
        output M68K_ADDR, M68K_DIN, nPORTOEL, nPORTOEU, nPORTWEL, nPORTWEU,
        output PROM_DATA, CFG_WR, CFG_ADDR, CFG_DATA,
        input  M68K_DOUT, M68K_DOE, P2_ADDR, ACTIVE
    );

    // Protection block side.
    modport slave (
        input  M68K_ADDR, M68K_DIN, nPORTOEL, nPORTOEU, nPORTWEL, nPORTWEU,
        input  PROM_DATA, CFG_WR, CFG_ADDR, CFG_DATA,
        output M68K_DOUT, M68K_DOE, P2_ADDR, ACTIVE
    );
endinterface

// File: rtl/neo_prot_bank.sv
// NeoGeo PORT protection + P2 bank controller with runtime-loaded config (bank reg, index scramble, bank table, ID, LFSR).
// Latency: P2_ADDR shows the new bank 3 cycles after a bank-write strobe falls; read data is combinational.
// Backpressure: none; bank writes arriving while a lookup is in flight are dropped. Option macro: NEO_PROT_BANK_READBACK_EN.
module neo_prot_bank #(
    parameter int                ADDR_W       = 19,
    parameter int                IDX_W        = 6,
    parameter int                P2_W         = 24,
    parameter int                RNG_W        = 16,
    parameter logic [RNG_W-1:0]  RNG_TAPS     = 16'h98EC,
    parameter logic [RNG_W-1:0]  RNG_SEED_DEF = 16'h2345
) (
    input  logic           CLK_24M,
    input  logic           nRESET,
    neo_prot_bank_if.slave bus
);
    localparam int TBL_DEPTH = 2 ** IDX_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // configuration registers
    logic                enable;
    logic [ADDR_W-1:0]   bank_addr;
    logic [ADDR_W-1:0]   rng_addr1;
    logic [ADDR_W-1:0]   rng_addr2;
    logic [ADDR_W-1:0]   id_addr;
    logic [15:0]         id_value;
    logic [4*IDX_W-1:0]  idx_sel;

    // bank table (not reset) and its registered read port
    logic [P2_W-1:0]     tbl [TBL_DEPTH];
    logic [P2_W-1:0]     tbl_rd;

    // bank FSM
    state_t              state;
    state_t              state_nxt;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    idx_nxt;
    logic [P2_W-1:0]     bank;

    // RNG
    logic [RNG_W-1:0]    rng;
    logic [RNG_W-1:0]    rng_nxt;
    logic                rng_pend;

    // strobe edge detection
    logic                we_now;
    logic                oe_now;
    logic                we_prev;
    logic                oe_prev;
    logic                we_fall;
    logic                oe_fall;
    logic                oe_rise;

    // decode
    logic                hit_bank;
    logic                hit_rng;
    logic                hit_id;
    logic                bank_go;
    logic                seed_wr;
    logic                cfg_tbl_hit;
    logic [IDX_W-1:0]    cfg_tbl_idx;
    logic [15:0]         dout;
    logic                unused_cfg_hi;

    assign we_now  = bus.nPORTWEL & bus.nPORTWEU;
    assign oe_now  = bus.nPORTOEL & bus.nPORTOEU;
    assign we_fall = we_prev & ~we_now;
    assign oe_fall = oe_prev & ~oe_now;
    assign oe_rise = ~oe_prev & oe_now;

    assign hit_bank = (bus.M68K_ADDR == bank_addr);
    assign hit_rng  = (bus.M68K_ADDR == rng_addr1) || (bus.M68K_ADDR == rng_addr2);
    assign hit_id   = (bus.M68K_ADDR == id_addr);

    // Only an IDLE FSM accepts a bank write; later falls are dropped.
    assign bank_go = we_fall && enable && hit_bank && (state == IDLE);

    assign seed_wr     = bus.CFG_WR && (bus.CFG_ADDR == 8'h07);
    assign cfg_tbl_hit = bus.CFG_WR && bus.CFG_ADDR[7] && (32'(bus.CFG_ADDR[6:0]) < TBL_DEPTH);
    assign cfg_tbl_idx = bus.CFG_ADDR[IDX_W-1:0];

    // Top config bits carry no field in any register.
    assign unused_cfg_hi = ^bus.CFG_DATA[31:P2_W];

    assign rng_nxt = {rng[RNG_W-2:0], ^(rng & RNG_TAPS)};

    // Register the combined strobes; idle high so reset release never fakes a fall.
    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            we_prev <= 1'b1;
            oe_prev <= 1'b1;
        end else begin
            we_prev <= we_now;
            oe_prev <= oe_now;
        end
    end

    // Config register file written by the cart loader.
    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            enable    <= 1'b0;
            bank_addr <= '0;
            rng_addr1 <= '0;
            rng_addr2 <= '0;
            id_addr   <= '0;
            id_value  <= '0;
            idx_sel   <= '0;
        end else if (bus.CFG_WR) begin
            case (bus.CFG_ADDR)
                8'h00:   enable    <= bus.CFG_DATA[0];
                8'h01:   bank_addr <= bus.CFG_DATA[ADDR_W-1:0];
                8'h02:   rng_addr1 <= bus.CFG_DATA[ADDR_W-1:0];
                8'h03:   rng_addr2 <= bus.CFG_DATA[ADDR_W-1:0];
                8'h04:   id_addr   <= bus.CFG_DATA[ADDR_W-1:0];
                8'h05:   id_value  <= bus.CFG_DATA[15:0];
                8'h06:   idx_sel   <= bus.CFG_DATA[4*IDX_W-1:0];
                default: ;
            endcase
        end
    end

    // Bank table: loader writes, FSM reads in LOOKUP; same-index collision returns the old entry.
    always_ff @(posedge CLK_24M) begin
        if (cfg_tbl_hit) begin
            tbl[cfg_tbl_idx] <= bus.CFG_DATA[P2_W-1:0];
        end
        if (state == LOOKUP) begin
            tbl_rd <= tbl[idx];
        end
    end

    // Scramble the written data into the table index: bit i comes from data bit idx_sel field i.
    always_comb begin
        idx_nxt = '0;
        for (int i = 0; i < IDX_W; i++) begin
            idx_nxt[i] = bus.M68K_DIN[idx_sel[4*i +: 4]];
        end
    end

    // Bank FSM state, latched index and committed bank.
    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            state <= IDLE;
            idx   <= '0;
            bank  <= '0;
        end else begin
            state <= state_nxt;
            if (bank_go) begin
                idx <= idx_nxt;
            end
            if (state == COMMIT) begin
                bank <= tbl_rd;
            end
        end
    end

    // Bank FSM next state; a pending commit completes even if ENABLE drops.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bank_go) state_nxt = LOOKUP;
            LOOKUP:  state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // LFSR: arm on an RNG read, step when that read ends so the 68K sees a stable value; seed load wins.
    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            rng      <= RNG_SEED_DEF;
            rng_pend <= 1'b0;
        end else begin
            if (oe_fall && enable && hit_rng) begin
                rng_pend <= 1'b1;
            end else if (oe_rise) begin
                rng_pend <= 1'b0;
            end
            if (seed_wr) begin
                rng <= bus.CFG_DATA[RNG_W-1:0];
            end else if (oe_rise && rng_pend) begin
                rng <= rng_nxt;
            end
        end
    end

`ifdef NEO_PROT_BANK_READBACK_EN
    logic [15:0] shadow;

    // Keep the raw data of the last accepted bank write for readback.
    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            shadow <= '0;
        end else if (bank_go) begin
            shadow <= bus.M68K_DIN;
        end
    end

    // Read mux: ID, then bank readback, then RNG, else ROM pass-through.
    always_comb begin
        dout = bus.PROM_DATA;
        if (enable) begin
            if (hit_id) begin
                dout = id_value;
            end else if (hit_bank) begin
                dout = shadow;
            end else if (hit_rng) begin
                dout = 16'(rng);
            end
        end
    end
`else
    // Read mux: ID, then RNG, else ROM pass-through.
    always_comb begin
        dout = bus.PROM_DATA;
        if (enable) begin
            if (hit_id) begin
                dout = id_value;
            end else if (hit_rng) begin
                dout = 16'(rng);
            end
        end
    end
`endif

    assign bus.M68K_DOUT = dout;
    assign bus.M68K_DOE  = enable ? {~bus.nPORTOEU, ~bus.nPORTOEL} : 2'b00;
    // Sum wraps modulo 2**P2_W.
    assign bus.P2_ADDR   = enable ? (bank + P2_W'({bus.M68K_ADDR, 1'b0})) : '0;
    assign bus.ACTIVE    = enable;

endmodule

// File: tb/tb_neo_prot_bank.sv
// Directed bench for neo_prot_bank: config load, bank lookup timing, LFSR, ID, reset abort, table collision, wrap.
// Expected values are queued when stimulus is driven and popped at each sample point.
// All sampling happens on the falling clock edge; inputs change on the falling edge too.
module tb_neo_prot_bank;
    logic CLK_24M = 1'b0;
    logic nRESET  = 1'b0;

    always #20 CLK_24M = ~CLK_24M;

    neo_prot_bank_if bus ();

    neo_prot_bank dut (
        .CLK_24M (CLK_24M),
        .nRESET  (nRESET),
        .bus     (bus)
    );

    localparam logic [18:0] BANK_A = 19'h7FFF8;
    localparam logic [18:0] RNG_A  = 19'h7FFFC;
    localparam logic [18:0] ID_A   = 19'h7F223;
    // Index fields 0..5 take data bits 14,8,6,10,12,5: 0x4040 -> idx 5, 0x4140 -> idx 7, 0x0000 -> idx 0.
    localparam logic [31:0] SEL    = 32'h005CA68E;

    logic [31:0] exp_q [$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] d;
    logic [1:0]  e;
    logic [15:0] rv [8];

    function automatic logic [15:0] lfsr(input logic [15:0] r);
        return {r[14:0], ^(r & 16'h98EC)};
    endfunction

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp_v;
        n_assert++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed %h, no expected value queued", tag, obs);
        end else begin
            exp_v = exp_q.pop_front();
            assert (obs === exp_v) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
            end
        end
    endtask

    task automatic cfg(input logic [7:0] a, input logic [31:0] v);
        @(negedge CLK_24M);
        bus.CFG_WR = 1'b1; bus.CFG_ADDR = a; bus.CFG_DATA = v;
        @(negedge CLK_24M);
        bus.CFG_WR = 1'b0;
    endtask

    task automatic rd(input logic [18:0] a, input logic up, input logic lo,
                      output logic [15:0] dd, output logic [1:0] ee);
        @(negedge CLK_24M);
        bus.M68K_ADDR = a; bus.nPORTOEU = ~up; bus.nPORTOEL = ~lo;
        @(negedge CLK_24M);
        dd = bus.M68K_DOUT; ee = bus.M68K_DOE;
        bus.nPORTOEU = 1'b1; bus.nPORTOEL = 1'b1;
        @(negedge CLK_24M);
    endtask

    task automatic bank_wr(input logic [15:0] din);
        @(negedge CLK_24M);
        bus.M68K_ADDR = BANK_A; bus.M68K_DIN = din;
        bus.nPORTWEL = 1'b0; bus.nPORTWEU = 1'b0;
        repeat (2) @(negedge CLK_24M);
        bus.nPORTWEL = 1'b1; bus.nPORTWEU = 1'b1;
        repeat (3) @(negedge CLK_24M);
    endtask

    task automatic base_cfg();
        cfg(8'h00, 32'd1);
        cfg(8'h01, {13'd0, BANK_A});
        cfg(8'h06, SEL);
    endtask

    initial begin
        bus.M68K_ADDR = '0; bus.M68K_DIN = '0; bus.PROM_DATA = 16'h1234;
        bus.nPORTOEL = 1'b1; bus.nPORTOEU = 1'b1; bus.nPORTWEL = 1'b1; bus.nPORTWEU = 1'b1;
        bus.CFG_WR = 1'b0; bus.CFG_ADDR = '0; bus.CFG_DATA = '0;

        // Reset state: disabled, outputs gated even with OE asserted.
        repeat (3) @(negedge CLK_24M);
        bus.M68K_ADDR = 19'h00123; bus.nPORTOEL = 1'b0; bus.nPORTOEU = 1'b0;
        @(negedge CLK_24M);
        push(32'd0);     check("rst_active", {31'd0, bus.ACTIVE});
        push(32'd0);     check("rst_doe", {30'd0, bus.M68K_DOE});
        push(32'd0);     check("rst_p2", {8'd0, bus.P2_ADDR});
        bus.nPORTOEL = 1'b1; bus.nPORTOEU = 1'b1;
        nRESET = 1'b1;

        // Enabled, bank 0: pass-through reads.
        cfg(8'h00, 32'd1);
        cfg(8'h80, 32'h000000);
        bus.PROM_DATA = 16'hBEEF;
        @(negedge CLK_24M);
        push(32'd1);     check("en_active", {31'd0, bus.ACTIVE});
        push(32'h246);   check("pass_p2", {8'd0, bus.P2_ADDR});
        push(32'd0);     check("idle_doe", {30'd0, bus.M68K_DOE});
        push(32'hBEEF);  push(32'h3);
        rd(19'h00123, 1'b1, 1'b1, d, e);
        check("pass_dout", {16'd0, d});
        check("pass_doe", {30'd0, e});

        // Bank write with scrambled index, exact commit timing.
        cfg(8'h01, {13'd0, BANK_A});
        cfg(8'h06, SEL);
        cfg(8'h85, 32'h3CC000);
        cfg(8'h83, 32'h111100);
        cfg(8'h87, 32'hFFFFF0);
        @(negedge CLK_24M);
        bus.M68K_ADDR = BANK_A; bus.M68K_DIN = 16'h4040;
        bus.nPORTWEL = 1'b0; bus.nPORTWEU = 1'b0;
        repeat (2) @(negedge CLK_24M);
        push(32'h0FFFF0); check("bank_2cyc_old", {8'd0, bus.P2_ADDR});
        bus.nPORTWEL = 1'b1; bus.nPORTWEU = 1'b1;
        @(negedge CLK_24M);
        push(32'h4CBFF0); check("bank_3cyc_new", {8'd0, bus.P2_ADDR});
        bus.M68K_ADDR = 19'h00010;
        @(negedge CLK_24M);
        push(32'h3CC020); check("bank_other_a", {8'd0, bus.P2_ADDR});

        // Read at the bank register address.
        bus.PROM_DATA = 16'h5555;
`ifdef NEO_PROT_BANK_READBACK_EN
        push(32'h4040);
`else
        push(32'h5555);
`endif
        rd(BANK_A, 1'b1, 1'b1, d, e);
        check("bank_read", {16'd0, d});

        // LFSR sequence, non-RNG read does not advance.
        rv[0] = 16'h2345;
        for (int i = 1; i < 8; i++) rv[i] = lfsr(rv[i-1]);
        cfg(8'h02, {13'd0, RNG_A});
        cfg(8'h07, 32'h2345);
        for (int i = 0; i < 3; i++) begin
            push({16'd0, rv[i]});
            rd(RNG_A, 1'b1, 1'b1, d, e);
            check("rng_seq", {16'd0, d});
        end
        push(32'h5555);
        rd(19'h00100, 1'b1, 1'b1, d, e);
        check("non_rng_dout", {16'd0, d});
        push({16'd0, rv[3]});
        rd(RNG_A, 1'b1, 1'b1, d, e);
        check("rng_no_adv", {16'd0, d});

        // ID read, both bytes then lower only; then ID overlapping an RNG address.
        cfg(8'h04, {13'd0, ID_A});
        cfg(8'h05, 32'h9A37);
        push(32'h9A37); push(32'h3);
        rd(ID_A, 1'b1, 1'b1, d, e);
        check("id_dout", {16'd0, d});
        check("id_doe11", {30'd0, e});
        push(32'h9A37); push(32'h1);
        rd(ID_A, 1'b0, 1'b1, d, e);
        check("id_lo_dout", {16'd0, d});
        check("id_doe01", {30'd0, e});
        cfg(8'h03, {13'd0, ID_A});
        push(32'h9A37);
        rd(ID_A, 1'b1, 1'b1, d, e);
        check("id_over_rng", {16'd0, d});
        push({16'd0, rv[5]});
        rd(RNG_A, 1'b1, 1'b1, d, e);
        check("rng_adv_by_id", {16'd0, d});
        cfg(8'h07, 32'hACE1);
        push(32'hACE1);
        rd(RNG_A, 1'b1, 1'b1, d, e);
        check("seed_load", {16'd0, d});

        // Reset during LOOKUP aborts; next write commits normally.
        @(negedge CLK_24M);
        bus.M68K_ADDR = BANK_A; bus.M68K_DIN = 16'h0000;
        bus.nPORTWEL = 1'b0; bus.nPORTWEU = 1'b0;
        @(negedge CLK_24M);
        #5 nRESET = 1'b0;
        @(negedge CLK_24M);
        bus.nPORTWEL = 1'b1; bus.nPORTWEU = 1'b1;
        nRESET = 1'b1;
        push(32'd0);     check("rst_mid_active", {31'd0, bus.ACTIVE});
        base_cfg();
        bus.M68K_ADDR = 19'h00010;
        @(negedge CLK_24M);
        push(32'h000020); check("rst_mid_bank0", {8'd0, bus.P2_ADDR});
        bank_wr(16'h4040);
        bus.M68K_ADDR = 19'h00010;
        @(negedge CLK_24M);
        push(32'h3CC020); check("post_rst_commit", {8'd0, bus.P2_ADDR});

        // Table overwrite during LOOKUP commits the old entry.
        bank_wr(16'h0000);
        @(negedge CLK_24M);
        bus.M68K_ADDR = BANK_A; bus.M68K_DIN = 16'h4040;
        bus.nPORTWEL = 1'b0; bus.nPORTWEU = 1'b0;
        @(negedge CLK_24M);
        bus.CFG_WR = 1'b1; bus.CFG_ADDR = 8'h85; bus.CFG_DATA = 32'h200000;
        @(negedge CLK_24M);
        bus.CFG_WR = 1'b0;
        bus.nPORTWEL = 1'b1; bus.nPORTWEU = 1'b1;
        @(negedge CLK_24M);
        push(32'h4CBFF0); check("collide_old", {8'd0, bus.P2_ADDR});
        bank_wr(16'h4040);
        push(32'h2FFFF0); check("collide_new", {8'd0, bus.P2_ADDR});

        // Wrap-around of bank + 2A.
        bank_wr(16'h4140);
        bus.M68K_ADDR = 19'h00010;
        @(negedge CLK_24M);
        push(32'h000010); check("p2_wrap", {8'd0, bus.P2_ADDR});

        // ENABLE cleared: outputs gated, bank held.
        cfg(8'h00, 32'd0);
        bus.nPORTOEL = 1'b0; bus.nPORTOEU = 1'b0;
        @(negedge CLK_24M);
        push(32'd0);     check("dis_p2", {8'd0, bus.P2_ADDR});
        push(32'd0);     check("dis_doe", {30'd0, bus.M68K_DOE});
        bus.nPORTOEL = 1'b1; bus.nPORTOEU = 1'b1;
        cfg(8'h00, 32'd1);
        @(negedge CLK_24M);
        push(32'h000010); check("reen_bank_held", {8'd0, bus.P2_ADDR});

        n_assert++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: %0d left, 0 required", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
